// File: rtl/sonar_scheduler.sv
// Round-robin ultrasonic ranging sequencer: triggers enabled sensors in turn and muxes echo to one capture unit.
// Optional SONAR_SCHED_TOCNT_EN adds a saturating timeout counter output to_count.
module sonar_scheduler #(
  parameter int N_CH           = 4,
  parameter int CHW            = 2,
  parameter int CW             = 8,
  parameter int TRIG_CYCLES    = 10,
  parameter int TIMEOUT_CYCLES = 300,
  parameter int GAP_CYCLES     = 50
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            continuous,
  input  logic [N_CH-1:0] ch_enable,
  input  logic [N_CH-1:0] echo,
  output logic [N_CH-1:0] trig,
  output logic            cap_signal,
  output logic            cap_rst,
  input  logic [CW-1:0]   cap_cnt,
  input  logic            cap_done,
  output logic [CW-1:0]   result,
  output logic [CHW-1:0]  result_ch,
  output logic            result_valid,
  output logic            result_timeout,
  output logic            busy
`ifdef SONAR_SCHED_TOCNT_EN
  ,
  output logic [7:0]      to_count
`endif
);

  localparam int TW = 16;

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_TRIG, S_WAIT, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [CHW-1:0]  ch_q, ch_d;
  logic [N_CH-1:0] en_q, en_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [CW-1:0]   result_d;
  logic [CHW-1:0]  result_ch_d;
  logic            result_timeout_d;
  logic            result_valid_d;
  logic            cap_rst_to_q, cap_rst_to_d;
  logic            to_inc;
  logic [CHW:0]    nxt;

  function automatic logic [CHW-1:0] lowest_ch(input logic [N_CH-1:0] m);
    lowest_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (m[i]) lowest_ch = CHW'(i);
  endfunction

  // {found, channel} of the lowest enabled channel strictly above cur
  function automatic logic [CHW:0] next_ch(input logic [N_CH-1:0] m, input logic [CHW-1:0] cur);
    next_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (m[i] && (i > int'(cur))) next_ch = {1'b1, CHW'(i)};
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign nxt = next_ch(en_q, ch_q);

  always_comb begin
    state_d          = state_q;
    ch_d             = ch_q;
    en_d             = en_q;
    timer_d          = timer_q + TW'(1);
    result_d         = result;
    result_ch_d      = result_ch;
    result_timeout_d = result_timeout;
    result_valid_d   = 1'b0;
    cap_rst_to_d     = 1'b0;
    to_inc           = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if ((start || continuous) && (ch_enable != '0)) begin
          state_d = S_SELECT;
          en_d    = ch_enable;
          ch_d    = lowest_ch(ch_enable);
        end
      end
      S_SELECT: begin
        timer_d = '0;
        state_d = S_TRIG;
      end
      S_TRIG: begin
        if (timer_q == TW'(TRIG_CYCLES - 1)) begin
          timer_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // a completed capture takes priority over an expiring timer
        if (cap_done) begin
          result_d         = cap_cnt;
          result_ch_d      = ch_q;
          result_timeout_d = 1'b0;
          result_valid_d   = 1'b1;
          timer_d          = '0;
          state_d          = S_GAP;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          result_d         = '1;
          result_ch_d      = ch_q;
          result_timeout_d = 1'b1;
          result_valid_d   = 1'b1;
          cap_rst_to_d     = 1'b1;
          to_inc           = 1'b1;
          timer_d          = '0;
          state_d          = S_GAP;
        end
      end
      S_GAP: begin
        if (timer_q == TW'(GAP_CYCLES - 1)) begin
          timer_d = '0;
          if (nxt[CHW]) begin
            ch_d    = nxt[CHW-1:0];
            state_d = S_SELECT;
          end else if (continuous && (ch_enable != '0)) begin
            en_d    = ch_enable;
            ch_d    = lowest_ch(ch_enable);
            state_d = S_SELECT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      ch_q           <= '0;
      en_q           <= '0;
      timer_q        <= '0;
      result         <= '0;
      result_ch      <= '0;
      result_timeout <= 1'b0;
      result_valid   <= 1'b0;
      cap_rst_to_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      ch_q           <= ch_d;
      en_q           <= en_d;
      timer_q        <= timer_d;
      result         <= result_d;
      result_ch      <= result_ch_d;
      result_timeout <= result_timeout_d;
      result_valid   <= result_valid_d;
      cap_rst_to_q   <= cap_rst_to_d;
    end
  end

`ifdef SONAR_SCHED_TOCNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        to_count <= '0;
    else if (to_inc) to_count <= sat_inc8(to_count);
  end
`else
  logic unused_to;
  assign unused_to = to_inc ^ (sat_inc8(8'h00) == 8'h00);
`endif

  // decoded from state so an async reset drops trig in the same cycle
  assign trig       = (state_q == S_TRIG) ? ({{(N_CH-1){1'b0}}, 1'b1} << ch_q) : '0;
  assign cap_signal = (state_q == S_WAIT) & echo[ch_q];
  assign cap_rst    = (state_q == S_SELECT) | cap_rst_to_q;
  assign busy       = (state_q != S_IDLE);

endmodule
